// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Divide-by-zero and signed overflow bypass the iteration and finish the cycle after acceptance.
module muldiv_unit #(
    parameter int D_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [D_WIDTH-1:0] aluop1,
    input  logic [D_WIDTH-1:0] regop2,
    output logic               ready,
    output logic               done,
    output logic [D_WIDTH-1:0] result
);
    localparam int W  = D_WIDTH;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [2:0]     op_q;
    logic           neg_q;
    logic [2*W-1:0] a_q;
    logic [2*W-1:0] acc;
    logic [W-1:0]   b_q;
    logic [W-1:0]   rem;

    // Operand conditioning at acceptance
    logic           s1, s2, neg_d, div0, ovf;
    logic [W-1:0]   mag1, mag2, fast_res;

    always_comb begin
        s1    = aluop1[W-1] && (op == 3'b001 || op == 3'b010 || op == 3'b100 || op == 3'b110);
        s2    = regop2[W-1] && (op == 3'b001 || op == 3'b100 || op == 3'b110);
        mag1  = s1 ? -aluop1 : aluop1;
        mag2  = s2 ? -regop2 : regop2;
        // REM follows the dividend sign; everything else is the sign product
        neg_d = (op[2] && op[1]) ? s1 : (s1 ^ s2);
        div0  = op[2] && (regop2 == '0);
        ovf   = op[2] && !op[0] && (aluop1 == {1'b1, {(W-1){1'b0}}}) && (regop2 == '1);
        fast_res = div0 ? (op[1] ? aluop1 : '1) : (op[1] ? '0 : aluop1);
    end

    // One iteration step plus final sign/selection from the post-step values,
    // so the result is already registered during the FIN cycle.
    logic [2*W-1:0] acc_n, prod_s;
    logic [W:0]     rem_sh, diff;
    logic [W-1:0]   rem_n, quo_s, rem_s, fin_res;

    always_comb begin
        rem_sh = {rem, a_q[W-1]};
        diff   = rem_sh - {1'b0, b_q};
        if (op_q[2]) begin
            rem_n = diff[W] ? rem_sh[W-1:0] : diff[W-1:0];
            acc_n = {acc[2*W-2:0], ~diff[W]};
        end else begin
            rem_n = rem;
            acc_n = acc + (b_q[0] ? a_q : '0);
        end
        prod_s = neg_q ? -acc_n : acc_n;
        quo_s  = neg_q ? -acc_n[W-1:0] : acc_n[W-1:0];
        rem_s  = neg_q ? -rem_n : rem_n;
        case (op_q)
            3'b000:                 fin_res = prod_s[W-1:0];
            3'b001, 3'b010, 3'b011: fin_res = prod_s[2*W-1:W];
            3'b100, 3'b101:         fin_res = quo_s;
            default:                fin_res = rem_s;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ready  <= 1'b1;
            done   <= 1'b0;
            result <= '0;
            cnt    <= '0;
            op_q   <= '0;
            neg_q  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            acc    <= '0;
            rem    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    op_q  <= op;
                    neg_q <= neg_d;
                    a_q   <= {{W{1'b0}}, mag1};
                    b_q   <= mag2;
                    acc   <= '0;
                    rem   <= '0;
                    cnt   <= '0;
                    ready <= 1'b0;
                    if (div0 || ovf) begin
                        result <= fast_res;
                        done   <= 1'b1;
                        state  <= FIN;
                    end else begin
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc <= acc_n;
                    rem <= rem_n;
                    a_q <= a_q << 1;
                    if (!op_q[2]) b_q <= b_q >> 1;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(W-1)) begin
                        result <= fin_res;
                        done   <= 1'b1;
                        state  <= FIN;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed RV32M cases at 32 bits and a randomised sweep at 8 bits,
// all checked against an arithmetic reference model.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        st32, st8;
    logic [2:0]  op32, op8;
    logic [31:0] a32, b32, res32;
    logic [7:0]  a8, b8, res8;
    logic        rdy32, dn32, rdy8, dn8;

    int checks = 0;
    int failures = 0;

    muldiv_unit #(.D_WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(st32), .op(op32), .aluop1(a32), .regop2(b32),
        .ready(rdy32), .done(dn32), .result(res32)
    );
    muldiv_unit #(.D_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(st8), .op(op8), .aluop1(a8), .regop2(b8),
        .ready(rdy8), .done(dn8), .result(res8)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint sext(input int w, input longint v);
        return v[w-1] ? v - (64'sd1 <<< w) : v;
    endfunction

    function automatic bit is_fast(input int w, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint mask, ua, ub;
        mask = (64'sd1 <<< w) - 1;
        ua = a & mask;
        ub = b & mask;
        return o[2] && (ub == 0 || (!o[0] && sext(w, ua) == -(64'sd1 <<< (w-1)) && sext(w, ub) == -1));
    endfunction

    // Reference: plain integer arithmetic on sign-extended values
    function automatic logic [31:0] model(input int w, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint mask, ua, ub, sa, sb, r;
        logic [63:0] p;
        bit ovf;
        mask = (64'sd1 <<< w) - 1;
        ua = a & mask;
        ub = b & mask;
        sa = sext(w, ua);
        sb = sext(w, ub);
        ovf = (sa == -(64'sd1 <<< (w-1))) && (sb == -1);
        case (o)
            3'd0: begin p = ua * ub; r = p & mask; end
            3'd1: begin p = sa * sb; r = (p >> w) & mask; end
            3'd2: begin p = sa * ub; r = (p >> w) & mask; end
            3'd3: begin p = ua * ub; r = (p >> w) & mask; end
            3'd4: r = (ub == 0) ? mask : ovf ? ua : ((sa / sb) & mask);
            3'd5: r = (ub == 0) ? mask : (ua / ub);
            3'd6: r = (ub == 0) ? ua : ovf ? 0 : ((sa % sb) & mask);
            default: r = (ub == 0) ? ua : (ua % ub);
        endcase
        return r[31:0];
    endfunction

    function automatic logic rdy(input int w);
        return (w == 32) ? rdy32 : rdy8;
    endfunction
    function automatic logic dn(input int w);
        return (w == 32) ? dn32 : dn8;
    endfunction
    function automatic logic [31:0] res(input int w);
        return (w == 32) ? res32 : {24'd0, res8};
    endfunction

    task automatic drive(input int w, input logic s, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (w == 32) begin
            st32 = s; op32 = o; a32 = a; b32 = b;
        end else begin
            st8 = s; op8 = o; a8 = a[7:0]; b8 = b[7:0];
        end
    endtask

    // Issue one op at a negedge, count negedges until done; spam keeps start high with junk operands.
    task automatic run(input int w, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit spam, output logic [31:0] r, output int lat, output int waits);
        waits = 0;
        lat = 0;
        r = '0;
        while (!rdy(w) && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        if (!rdy(w)) begin
            check("ready_timeout", 64'(rdy(w)), 64'd1);
            return;
        end
        drive(w, 1'b1, o, a, b);
        @(negedge clk);
        lat = 1;
        drive(w, spam, 3'($urandom), $urandom, $urandom);
        while (!dn(w) && lat < 100) begin
            if (spam) drive(w, 1'b1, 3'($urandom), $urandom, $urandom);
            @(negedge clk);
            lat++;
        end
        drive(w, 1'b0, 3'd0, 32'd0, 32'd0);
        r = res(w);
    endtask

    task automatic exec(input int w, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit spam, output logic [31:0] r, output int waits);
        logic [31:0] exp;
        int lat, elat;
        exp  = model(w, o, a, b);
        elat = is_fast(w, o, a, b) ? 1 : w + 1;
        run(w, o, a, b, spam, r, lat, waits);
        check($sformatf("w%0d_op%0d_%0h_%0h_result", w, o, a, b), 64'(r), 64'(exp));
        check($sformatf("w%0d_op%0d_%0h_%0h_latency", w, o, a, b), 64'(lat), 64'(elat));
    endtask

    initial begin
        logic [31:0] r, a, b;
        int waits, pulses;

        rst = 1'b1;
        drive(32, 1'b0, 3'd0, 32'd0, 32'd0);
        drive(8, 1'b0, 3'd0, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        check("reset_ready", 64'(rdy32), 64'd1);
        check("reset_done", 64'(dn32), 64'd0);
        check("reset_result", 64'(res32), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Multiply corners
        exec(32, 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, r, waits); check("mul_ff", 64'(r), 64'h00000001);
        exec(32, 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, r, waits); check("mulh_ff", 64'(r), 64'h00000000);
        exec(32, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, r, waits); check("mulhu_ff", 64'(r), 64'hFFFFFFFE);
        exec(32, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, r, waits); check("mulhsu_ff", 64'(r), 64'hFFFFFFFF);

        // Division
        exec(32, 3'd4, -32'sd7, 32'd2, 1'b0, r, waits);         check("div_m7_2", 64'(r), 64'hFFFFFFFD);
        exec(32, 3'd6, -32'sd7, 32'd2, 1'b0, r, waits);         check("rem_m7_2", 64'(r), 64'hFFFFFFFF);
        exec(32, 3'd5, 32'h80000000, 32'd3, 1'b0, r, waits);    check("divu_big_3", 64'(r), 64'h2AAAAAAA);
        exec(32, 3'd7, 32'h80000000, 32'd3, 1'b0, r, waits);    check("remu_big_3", 64'(r), 64'd2);

        // Fast path
        exec(32, 3'd4, 32'd5, 32'd0, 1'b0, r, waits);                  check("div_by0", 64'(r), 64'hFFFFFFFF);
        exec(32, 3'd6, 32'd5, 32'd0, 1'b0, r, waits);                  check("rem_by0", 64'(r), 64'd5);
        exec(32, 3'd4, 32'h80000000, 32'hFFFFFFFF, 1'b0, r, waits);    check("div_ovf", 64'(r), 64'h80000000);
        exec(32, 3'd6, 32'h80000000, 32'hFFFFFFFF, 1'b0, r, waits);    check("rem_ovf", 64'(r), 64'd0);
        exec(32, 3'd4, 32'd9, 32'd0, 1'b0, r, waits);
        check("fast_b2b_waits", 64'(waits), 64'd1);

        // Reset mid-CALC of DIVU 100/7; no done may follow
        @(negedge clk);
        drive(32, 1'b1, 3'd5, 32'd100, 32'd7);
        @(negedge clk);
        drive(32, 1'b0, 3'd0, 32'd0, 32'd0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midcalc_rst_ready", 64'(rdy32), 64'd1);
        check("midcalc_rst_done", 64'(dn32), 64'd0);
        check("midcalc_rst_result", 64'(res32), 64'd0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (dn32) pulses++;
        end
        check("midcalc_rst_no_done", 64'(pulses), 64'd0);

        // Start spam during CALC is ignored; start right after FIN is taken
        exec(32, 3'd5, 32'd1000, 32'd7, 1'b1, r, waits);  check("spam_divu", 64'(r), 64'd142);
        exec(32, 3'd0, 32'd3, 32'd5, 1'b0, r, waits);     check("after_fin_mul", 64'(r), 64'd15);
        check("after_fin_waits", 64'(waits), 64'd1);

        // 8-bit sweep with sprinkled divide-by-zero and overflow operands
        for (int o = 0; o < 8; o++) begin
            for (int i = 0; i < 500; i++) begin
                a = $urandom;
                b = $urandom;
                if (i % 40 == 0) b = 32'd0;
                if (i % 40 == 1) begin a = 32'h80; b = 32'hFF; end
                exec(8, 3'(o), a, b, 1'b0, r, waits);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
